dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arb_pick.sv | 28 ++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared widths and port tags for the data-memory arbiter (defaults mirror config.inc.v).
// Build option DMEM_ARB_ROUND_ROBIN_EN selects burst-limited round robin over fixed priority.
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 12
`endif
`ifndef DMEM_DATA_WIDTH
`define DMEM_DATA_WIDTH 32
`endif
`ifndef DMEM_ARB_PORT_CPU
`define DMEM_ARB_PORT_CPU 0
`endif
`ifndef DMEM_ARB_PORT_DBG
`define DMEM_ARB_PORT_DBG 1
`endif

package dmem_arbiter_pkg;
    localparam int unsigned DMEM_ADDR_W = `DMEM_ADDR_WIDTH;
    localparam int unsigned DMEM_DATA_W = `DMEM_DATA_WIDTH;

    typedef enum logic {
        PORT_CPU = 1'(`DMEM_ARB_PORT_CPU),
        PORT_DBG = 1'(`DMEM_ARB_PORT_DBG)
    } port_e;
endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection for the two data-memory requesters.
// DMEM_ARB_ROUND_ROBIN_EN selects owner/burst arbitration; otherwise port 0 has fixed priority.
module dmem_arb_pick (
    input  logic [1:0] req,
    input  logic       owner,
    input  logic       burst_full,
    output logic [1:0] gnt
);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // On contention the owner wins unless its burst is exhausted.
    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = '0;
            gnt[owner ^ burst_full] = 1'b1;
        end
    end
`else
    logic unused_rr_inputs;
    assign unused_rr_inputs = owner ^ burst_full;

    always_comb begin
        gnt = '0;
        if (req[0])      gnt[0] = 1'b1;
        else if (req[1]) gnt[1] = 1'b1;
    end
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory; routes read data back by tag.
// DMEM_ARB_ROUND_ROBIN_EN enables the owner/burst_cnt registers for burst-limited round robin.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DMEM_ADDR_W,
    parameter int unsigned DATA_WIDTH = DMEM_DATA_W,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wenable,
    output logic [DATA_WIDTH-1:0] mem_wvalue,
    input  logic [DATA_WIDTH-1:0] mem_rvalue
);
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  gnt_any;
    port_e                 gnt_port;
    logic                  owner_bit;
    logic                  burst_full;
    logic                  rd_issue;
    logic                  rd_pend;
    port_e                 rd_tag;
    logic [DATA_WIDTH-1:0] p0_rdata_q;
    logic [DATA_WIDTH-1:0] p1_rdata_q;

    assign req = {p1_req, p0_req};

    dmem_arb_pick u_pick (
        .req        (req),
        .owner      (owner_bit),
        .burst_full (burst_full),
        .gnt        (gnt)
    );

    assign p0_gnt   = gnt[0];
    assign p1_gnt   = gnt[1];
    assign gnt_any  = |gnt;
    assign gnt_port = gnt[1] ? PORT_DBG : PORT_CPU;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    port_e              owner;
    logic [BURST_W-1:0] burst_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= PORT_CPU;
            burst_cnt <= '0;
        end else if (!gnt_any) begin
            burst_cnt <= '0;
        end else if (gnt_port == owner) begin
            if (burst_cnt != BURST_W'(MAX_BURST))
                burst_cnt <= burst_cnt + 1'b1;
        end else begin
            owner     <= gnt_port;
            burst_cnt <= BURST_W'(1);
        end
    end

    assign owner_bit  = (owner == PORT_DBG);
    assign burst_full = (burst_cnt == BURST_W'(MAX_BURST));
`else
    localparam int unsigned unused_max_burst = MAX_BURST;

    assign owner_bit  = 1'b0;
    assign burst_full = 1'b0;
`endif

    always_comb begin
        mem_addr    = '0;
        mem_wenable = 1'b0;
        mem_wvalue  = '0;
        if (gnt[0]) begin
            mem_addr    = p0_addr;
            mem_wenable = p0_we;
            mem_wvalue  = p0_wdata;
        end else if (gnt[1]) begin
            mem_addr    = p1_addr;
            mem_wenable = p1_we;
            mem_wvalue  = p1_wdata;
        end
    end

    assign rd_issue = gnt_any && !mem_wenable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_tag  <= PORT_CPU;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue)
                rd_tag <= gnt_port;
        end
    end

    assign p0_rvalid = rd_pend && (rd_tag == PORT_CPU);
    assign p1_rvalid = rd_pend && (rd_tag == PORT_DBG);

    // Memory data is live during the valid cycle; the register holds it afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            if (p0_rvalid) p0_rdata_q <= mem_rvalue;
            if (p1_rvalid) p1_rdata_q <= mem_rvalue;
        end
    end

    assign p0_rdata = p0_rvalid ? mem_rvalue : p0_rdata_q;
    assign p1_rdata = p1_rvalid ? mem_rvalue : p1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant history, issue-ordered shadow memory, read return queue).
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned AW = DMEM_ADDR_W;
    localparam int unsigned DW = DMEM_DATA_W;
    localparam int          MB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wenable;
    logic [DW-1:0] mem_wvalue, mem_rvalue;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wenable(mem_wenable), .mem_wvalue(mem_wvalue),
        .mem_rvalue(mem_rvalue)
    );

    // Synchronous single-port memory stand-in, cleared while reset is held.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_wenable) begin
            mem[mem_addr[7:0]] <= mem_wvalue;
        end
        mem_rvalue <= mem[mem_addr[7:0]];
    end

    // Reference model state.
    int            m_last, m_run, m_rport, w_last;
    bit            m_rv;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] ref_mem [256];
    logic          g0, g1;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            exp_pat [9];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 0; m_run = 0; m_rv = 0; m_rport = 0; m_rdata = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    endtask

    function automatic int pick_model(input logic r0, input logic r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        return (m_run >= MB) ? 1 - m_last : m_last;
`else
        return 0;
`endif
    endfunction

    // One clock: check every output at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int            w;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        @(negedge clk);
        w  = pick_model(p0_req, p1_req);
        a  = (w == 0) ? p0_addr  : (w == 1) ? p1_addr  : '0;
        we = (w == 0) ? p0_we    : (w == 1) ? p1_we    : 1'b0;
        wd = (w == 0) ? p0_wdata : (w == 1) ? p1_wdata : '0;
        chk("p0_gnt", 64'(p0_gnt), 64'(w == 0));
        chk("p1_gnt", 64'(p1_gnt), 64'(w == 1));
        chk("mem_addr", 64'(mem_addr), 64'(a));
        chk("mem_wenable", 64'(mem_wenable), 64'(we));
        chk("mem_wvalue", 64'(mem_wvalue), 64'(wd));
        chk("p0_rvalid", 64'(p0_rvalid), 64'(m_rv && m_rport == 0));
        chk("p1_rvalid", 64'(p1_rvalid), 64'(m_rv && m_rport == 1));
        chk("p0_rdata", 64'(p0_rdata), 64'((m_rv && m_rport == 0) ? m_rdata : exp_rd[0]));
        chk("p1_rdata", 64'(p1_rdata), 64'((m_rv && m_rport == 1) ? m_rdata : exp_rd[1]));
        g0 = p0_gnt; g1 = p1_gnt; w_last = w;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (m_rv) exp_rd[m_rport] = m_rdata;
            m_rv    = (w >= 0) && !we;
            m_rport = w;
            if (m_rv) m_rdata = ref_mem[a[7:0]];
            if (w >= 0 && we) ref_mem[a[7:0]] = wd;
            if (w < 0) m_run = 0;
            else if (w == m_last) begin if (m_run < MB) m_run++; end
            else begin m_last = w; m_run = 1; end
        end
        #1;
    endtask

    task automatic retire();
        if (!reset) begin
            if (w_last == 0) p0_req = 1'b0;
            if (w_last == 1) p1_req = 1'b0;
        end
    endtask

    task automatic req0(input logic we, input int addr, input logic [DW-1:0] wd);
        p0_req = 1'b1; p0_we = we; p0_addr = AW'(addr); p0_wdata = wd;
    endtask

    task automatic req1(input logic we, input int addr, input logic [DW-1:0] wd);
        p1_req = 1'b1; p1_we = we; p1_addr = AW'(addr); p1_wdata = wd;
    endtask

    initial begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
        exp_pat = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        reset = 1'b1;
        model_reset();

        // Reset held with a p0 read pending, then release.
        req0(1'b0, 'h12, '0);
        cycle();
        chk("t1_rst_p0_rvalid", 64'(p0_rvalid), 64'(0));
        chk("t1_rst_p0_rdata", 64'(p0_rdata), 64'(0));
        reset = 1'b0;
        cycle();
        chk("t1_gnt", 64'(g0), 64'(1));
        chk("t1_rvalid", 64'(p0_rvalid), 64'(1));
        retire();

        // Write then read back on consecutive cycles.
        req0(1'b1, 'h12, DW'('h5A));
        cycle(); retire();
        req0(1'b0, 'h12, '0);
        cycle();
        chk("t2_gnt", 64'(g0), 64'(1));
        retire();
        chk("t2_rvalid", 64'(p0_rvalid), 64'(1));
        chk("t2_rdata", 64'(p0_rdata), 64'('h5A));
        cycle();

        // Contention: p0 write vs p1 read.
        req0(1'b1, 'h20, DW'('h77));
        req1(1'b0, 'h12, '0);
        cycle();
        chk("t3_single_gnt", 64'(g0 + g1), 64'(1));
        retire();
        cycle(); retire();
        chk("t3_p1_rvalid", 64'(p1_rvalid), 64'(1));
        chk("t3_p0_rvalid", 64'(p0_rvalid), 64'(0));
        chk("t3_p1_rdata", 64'(p1_rdata), 64'('h5A));
        cycle();

        // Both ports request continuously from a fresh reset.
        reset = 1'b1; model_reset();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            req0(1'b0, i, '0);
            req1(1'b0, i + 8, '0);
            cycle();
            chk("t4_pattern_p1", 64'(g1), 64'(exp_pat[i]));
        end
        p0_req = 0; p1_req = 0;
        cycle(); cycle();

        // Alternating reads; returns must land on the issuing port each cycle.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) req0(1'b0, i, '0); else req1(1'b0, i, '0);
            cycle(); retire();
            chk("t5_rvalid_issuer", 64'((i % 2 == 0) ? p0_rvalid : p1_rvalid), 64'(1));
            chk("t5_rvalid_other", 64'((i % 2 == 0) ? p1_rvalid : p0_rvalid), 64'(0));
        end
        cycle();

        // Reset right after a p1 read grant discards the return.
        req1(1'b0, 3, '0);
        cycle(); retire();
        reset = 1'b1; model_reset();
        #1;
        chk("t6_p1_rvalid", 64'(p1_rvalid), 64'(0));
        cycle();
        reset = 1'b0;
        req0(1'b0, 1, '0);
        req1(1'b0, 2, '0);
        cycle();
        chk("t6_owner_reset", 64'(g0), 64'(1));
        retire();
        cycle(); retire();
        cycle();

        // Random traffic with occasional withdrawals.
        for (int c = 0; c < 400; c++) begin
            if (!p0_req) begin
                if ($urandom_range(2) != 0)
                    req0(1'($urandom_range(1)), int'($urandom_range(15)), DW'($urandom));
            end else if ($urandom_range(15) == 0) begin
                p0_req = 1'b0;
            end
            if (!p1_req) begin
                if ($urandom_range(2) != 0)
                    req1(1'($urandom_range(1)), int'($urandom_range(15)), DW'($urandom));
            end else if ($urandom_range(15) == 0) begin
                p1_req = 1'b0;
            end
            cycle(); retire();
        end
        p0_req = 0; p1_req = 0;
        cycle(); cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
